div_32_iter: RTL and testbench



---
 rtl/div_32_iter_pkg.sv | 19 +
 rtl/div_32_iter_if.sv | 26 ++
 rtl/div_32_iter_step.sv | 26 ++
 rtl/div_32_iter.sv | 116 +++++++++++
 tb/tb_div_32_iter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/div_32_iter_pkg.sv
// Shared types and constants for the iterative 32-bit DIV/DIVU unit.
// State encoding, operand width and the counter-width helper live here.
package div_32_iter_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // One extra bit so the counter can step past WIDTH-1 without wrapping.
    function automatic int div_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_32_iter_if.sv
// Pipeline-to-divider handshake: operands and control in, stall/busy and hi/lo out.
// The pipeline drives the master side; the divider implements the slave side.
interface div_32_iter_if
    import div_32_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             stalled;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, opA, opB,
        input  stalled, busy, hi, lo
    );

    modport slave (
        input  start, is_signed, opA, opB,
        output stalled, busy, hi, lo
    );
endinterface

// File: rtl/div_32_iter_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and record the quotient bit.
module div_32_iter_step
    import div_32_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_next_o,
    output logic [WIDTH-1:0] q_next_o
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             ge;

    // Extra top bit acts as the borrow: clear means shifted >= divisor.
    always_comb begin
        shifted    = {rem_i, q_i[WIDTH-1]};
        diff       = {1'b0, shifted} - {2'b00, divisor_i};
        ge         = ~diff[WIDTH+1];
        rem_next_o = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_next_o   = {q_i[WIDTH-2:0], ge};
    end
endmodule

// File: rtl/div_32_iter.sv
// Iterative restoring DIV/DIVU: one quotient bit per cycle, sign fix-up in a
// dedicated cycle, quotient to lo and remainder to hi.
module div_32_iter
    import div_32_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    div_32_iter_if.slave bus
);
    localparam int CNT_W = div_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] divisor_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             busy_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] rem_d;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // Magnitude of the most negative value is 2^(WIDTH-1) as unsigned, so no overflow.
    always_comb begin
        sign_a = bus.is_signed & bus.opA[WIDTH-1];
        sign_b = bus.is_signed & bus.opB[WIDTH-1];
        mag_a  = sign_a ? (~bus.opA + 1'b1) : bus.opA;
        mag_b  = sign_b ? (~bus.opB + 1'b1) : bus.opB;
    end

    div_32_iter_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i      (rem_q),
        .q_i        (quo_q),
        .divisor_i  (divisor_q),
        .rem_next_o (rem_d),
        .q_next_o   (quo_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        quo_q     <= mag_a;
                        divisor_q <= mag_b;
                        neg_quo_q <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        rem_q     <= '0;
                        count_q   <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_STEP) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    lo_q    <= neg_quo_q ? (~quo_q + 1'b1) : quo_q;
                    hi_q    <= neg_rem_q ? (~rem_q + 1'b1) : rem_q;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    // start is still high here for the issuing instruction; it must not relaunch.
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.stalled = 1'b0;
        case (state_q)
            ST_IDLE: bus.stalled = bus.start;
            ST_BUSY: bus.stalled = 1'b1;
            ST_FIX:  bus.stalled = 1'b1;
            default: bus.stalled = 1'b0;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_div_32_iter.sv
// Scoreboard bench for div_32_iter: expected hi/lo queued at issue, popped when
// stalled drops, plus stall-length, reset, flush and back-to-back checks.
module tb_div_32_iter;
    import div_32_iter_pkg::*;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t sb_q[$];
    exp_t last_exp;

    div_32_iter_if bus ();

    div_32_iter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] lo, input logic [31:0] hi);
        exp_t e;
        e.lo = lo;
        e.hi = hi;
        return e;
    endfunction

    // Reference: divide magnitudes, divide-by-zero gives all-ones quotient, then fix signs.
    function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ma, mb, q, r;
        logic        na, nb;
        na = s & a[31];
        nb = s & b[31];
        ma = na ? (32'd0 - a) : a;
        mb = nb ? (32'd0 - b) : b;
        if (mb == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        return mk((na ^ nb) ? (32'd0 - q) : q, na ? (32'd0 - r) : r);
    endfunction

    // Entered and left at posedge+1. drop_at >= 0 lowers start after that many stalled cycles.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input exp_t e, input int drop_at, input bit hold);
        int   stalls;
        exp_t got_e;
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.opA       = a;
        bus.opB       = b;
        sb_q.push_back(e);
        stalls = 0;
        for (int guard = 0; guard < 100; guard++) begin
            @(negedge clk);
            if (!bus.stalled) break;
            stalls++;
            if (stalls == 2) chk("busy_mid", {31'd0, bus.busy}, 32'd1);
            @(posedge clk);
            #1;
            if (stalls == drop_at) bus.start = 1'b0;
        end
        chk("stall_len", stalls, 32'd34);
        chk("busy_done", {31'd0, bus.busy}, 32'd1);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            got_e = sb_q.pop_front();
            chk("lo", bus.lo, got_e.lo);
            chk("hi", bus.hi, got_e.hi);
            last_exp = got_e;
        end
        $display("div a=%h b=%h s=%0d -> lo=%h hi=%h stalls=%0d", a, b, s, bus.lo, bus.hi, stalls);
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.start = 1'b0;
            @(negedge clk);
            chk("busy_idle", {31'd0, bus.busy}, 32'd0);
            chk("stall_idle", {31'd0, bus.stalled}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.opA       = '0;
        bus.opB       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_stall0", {31'd0, bus.stalled}, 32'd0);
        bus.start = 1'b1;
        #1;
        chk("rst_stall1", {31'd0, bus.stalled}, 32'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        reset     = 1'b0;

        do_div(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2), -1, 1'b0);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF), -1, 1'b0);
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, mk(32'hFFFF_FFFD, 32'd1), -1, 1'b0);
        do_div(32'd5, 32'd0, 1'b0, mk(32'hFFFF_FFFF, 32'd5), -1, 1'b0);
        do_div(32'hFFFF_FFFB, 32'd0, 1'b1, mk(32'd1, 32'hFFFF_FFFB), -1, 1'b0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'h8000_0000, 32'd0), -1, 1'b0);
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, mk(32'hFFFF_FFFF, 32'd0), -1, 1'b0);

        // hi/lo must hold while idle with new operands present.
        bus.opA = 32'd77;
        bus.opB = 32'd5;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("hold_lo", bus.lo, last_exp.lo);
        chk("hold_hi", bus.hi, last_exp.hi);
        @(posedge clk);
        #1;

        // Pipeline flush: start drops mid-divide, result still lands.
        do_div(32'd1000, 32'd33, 1'b0, mk(32'd30, 32'd10), 5, 1'b0);

        // Reset at BUSY count=10 (cycle 11).
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.opA       = 32'd500;
        bus.opB       = 32'd3;
        repeat (11) @(posedge clk);
        #1;
        reset     = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_hi", bus.hi, 32'd0);
        chk("mid_rst_lo", bus.lo, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_stall0", {31'd0, bus.stalled}, 32'd0);
        bus.start = 1'b1;
        #1;
        chk("mid_rst_stall1", {31'd0, bus.stalled}, 32'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        reset     = 1'b0;
        do_div(32'd123456, 32'hFFFF_FCEB, 1'b1, ref_div(32'd123456, 32'hFFFF_FCEB, 1'b1), -1, 1'b0);

        // Back-to-back with start held across both.
        do_div(32'd9, 32'd3, 1'b0, mk(32'd3, 32'd0), -1, 1'b1);
        do_div(32'd10, 32'd4, 1'b0, mk(32'd2, 32'd2), -1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? ($urandom & 32'hFF) : $urandom;
            if (i == 4) rb = 32'd0;
            rs = 1'($urandom_range(0, 1));
            do_div(ra, rb, rs, ref_div(ra, rb, rs), -1, 1'b0);
        end

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
